// File: rtl/ysyx_22040237_mcyc_ctrl.sv
// Multi-cycle sequencer for the RV64 core datapath.
// Owns pc and the instruction register, runs the fetch and data-memory
// valid/ready handshakes, and walks the combinational decoder/ALU through
// FETCH -> WAIT_I -> DECODE -> EXEC -> (MEM -> WAIT_D) -> WB.
// Register-file writes and pc updates happen once per instruction, in WB.
// ebreak parks the core in HALT; faults park it in TRAP with a reason code.
module ysyx_22040237_mcyc_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    // instruction fetch port
    output logic        if_req_valid,
    input  logic        if_req_ready,
    output logic [63:0] if_addr,
    input  logic        if_resp_valid,
    input  logic [31:0] if_resp_inst,
    // decoder / ALU interface
    output logic [31:0] ir,
    output logic [63:0] pc,
    input  logic        dec_invalid,
    input  logic        dec_ebreak,
    input  logic        dec_jump,
    input  logic        dec_rd_w_en,
    input  logic        dec_mem_en,
    input  logic        dec_mem_wr,
    input  logic [63:0] jump_target,
    // data memory port
    output logic        mem_req_valid,
    output logic        mem_req_we,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    // write-back strobe and status
    output logic        rf_we,
    output logic        halt,
    output logic        trap,
    output logic [2:0]  trap_code,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
);

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_WAIT_I = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC   = 4'd3,
        ST_MEM    = 4'd4,
        ST_WAIT_D = 4'd5,
        ST_WB     = 4'd6,
        ST_HALT   = 4'd7,
        ST_TRAP   = 4'd8
    } state_t;

    localparam logic [2:0] CODE_INVALID    = 3'd1;
    localparam logic [2:0] CODE_FETCH_TMO  = 3'd2;
    localparam logic [2:0] CODE_LOAD_TMO   = 3'd3;
    localparam logic [2:0] CODE_MISALIGNED = 3'd4;

    state_t      state_r;
    logic [63:0] pc_r;
    logic [31:0] ir_r;
    logic        if_req_valid_r;
    logic        mem_req_valid_r;
    logic        mem_req_we_r;
    logic        rf_we_r;
    logic        halt_r;
    logic        trap_r;
    logic [2:0]  trap_code_r;
    logic [63:0] cycle_cnt_r;
    logic [63:0] instret_cnt_r;
    logic [7:0]  wdog_r;

    logic [63:0] target_s;
    logic        misalign_s;
    logic [63:0] pc_next_s;
    logic        wb_we_s;
    logic [7:0]  wdog_inc_s;
    logic        wdog_expire_s;
    logic        running_s;

    // Next-pc, write-back qualification and watchdog expiry helpers
    always_comb begin
        // jalr-style target: bit 0 is always dropped
        target_s      = jump_target & ~64'd1;
        // a taken jump must land on a 4-byte boundary
        misalign_s    = dec_jump & target_s[1];
        if (dec_jump) begin
            pc_next_s = target_s;
        end else begin
            pc_next_s = pc_r + 64'd4;
        end
        // the write strobe is suppressed when WB will trap instead of retire
        wb_we_s       = dec_rd_w_en & ~misalign_s;
        wdog_inc_s    = wdog_r + 8'd1;
        wdog_expire_s = (wdog_inc_s == TIMEOUT);
        running_s     = (state_r != ST_HALT) && (state_r != ST_TRAP);
    end

    // Sequencer FSM with registered handshake outputs, strobes and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_FETCH;
            pc_r            <= RESET_PC;
            ir_r            <= 32'd0;
            if_req_valid_r  <= 1'b1;
            mem_req_valid_r <= 1'b0;
            mem_req_we_r    <= 1'b0;
            rf_we_r         <= 1'b0;
            halt_r          <= 1'b0;
            trap_r          <= 1'b0;
            trap_code_r     <= 3'd0;
            cycle_cnt_r     <= 64'd0;
            instret_cnt_r   <= 64'd0;
            wdog_r          <= 8'd0;
        end else begin
            // rf_we is a single-cycle pulse; the watchdog restarts on every
            // state entry and only the wait states keep it counting
            rf_we_r <= 1'b0;
            wdog_r  <= 8'd0;
            if (running_s) begin
                cycle_cnt_r <= cycle_cnt_r + 64'd1;
            end
            case (state_r)
                ST_FETCH: begin
                    if (if_req_ready) begin
                        if_req_valid_r <= 1'b0;
                        state_r        <= ST_WAIT_I;
                    end
                end
                ST_WAIT_I: begin
                    if (if_resp_valid) begin
                        ir_r    <= if_resp_inst;
                        state_r <= ST_DECODE;
                    end else if (wdog_expire_s) begin
                        trap_r      <= 1'b1;
                        trap_code_r <= CODE_FETCH_TMO;
                        state_r     <= ST_TRAP;
                    end else begin
                        wdog_r <= wdog_inc_s;
                    end
                end
                ST_DECODE: begin
                    // an invalid encoding wins over ebreak
                    if (dec_invalid) begin
                        trap_r      <= 1'b1;
                        trap_code_r <= CODE_INVALID;
                        state_r     <= ST_TRAP;
                    end else if (dec_ebreak) begin
                        halt_r  <= 1'b1;
                        state_r <= ST_HALT;
                    end else begin
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (dec_mem_en) begin
                        mem_req_valid_r <= 1'b1;
                        mem_req_we_r    <= dec_mem_wr;
                        state_r         <= ST_MEM;
                    end else begin
                        // operands are stable since DECODE, so the WB strobe
                        // can be registered on the way in
                        rf_we_r <= wb_we_s;
                        state_r <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (mem_req_ready) begin
                        mem_req_valid_r <= 1'b0;
                        mem_req_we_r    <= 1'b0;
                        if (mem_req_we_r) begin
                            // stores need no response
                            rf_we_r <= wb_we_s;
                            state_r <= ST_WB;
                        end else begin
                            state_r <= ST_WAIT_D;
                        end
                    end
                end
                ST_WAIT_D: begin
                    if (mem_resp_valid) begin
                        rf_we_r <= wb_we_s;
                        state_r <= ST_WB;
                    end else if (wdog_expire_s) begin
                        trap_r      <= 1'b1;
                        trap_code_r <= CODE_LOAD_TMO;
                        state_r     <= ST_TRAP;
                    end else begin
                        wdog_r <= wdog_inc_s;
                    end
                end
                ST_WB: begin
                    if (misalign_s) begin
                        trap_r      <= 1'b1;
                        trap_code_r <= CODE_MISALIGNED;
                        state_r     <= ST_TRAP;
                    end else begin
                        pc_r           <= pc_next_s;
                        instret_cnt_r  <= instret_cnt_r + 64'd1;
                        if_req_valid_r <= 1'b1;
                        state_r        <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                ST_TRAP: begin
                    state_r <= ST_TRAP;
                end
                default: begin
                    // unreachable encoding: restart cleanly at a fetch
                    if_req_valid_r  <= 1'b1;
                    mem_req_valid_r <= 1'b0;
                    mem_req_we_r    <= 1'b0;
                    state_r         <= ST_FETCH;
                end
            endcase
        end
    end

    assign if_req_valid  = if_req_valid_r;
    assign if_addr       = pc_r;
    assign pc            = pc_r;
    assign ir            = ir_r;
    assign mem_req_valid = mem_req_valid_r;
    assign mem_req_we    = mem_req_we_r;
    assign rf_we         = rf_we_r;
    assign halt          = halt_r;
    assign trap          = trap_r;
    assign trap_code     = trap_code_r;
    assign cycle_cnt     = cycle_cnt_r;
    assign instret_cnt   = instret_cnt_r;

endmodule

// File: tb/tb_ysyx_22040237_mcyc_ctrl.sv
// Directed bench for the multi-cycle sequencer: the bench plays decoder,
// ALU and both memories, and checks every observation against hand-computed
// values with immediate assertions.
module tb_ysyx_22040237_mcyc_ctrl;

    localparam logic [63:0] RPC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [63:0] if_addr;
    logic        if_resp_valid;
    logic [31:0] if_resp_inst;
    logic [31:0] ir;
    logic [63:0] pc;
    logic        dec_invalid;
    logic        dec_ebreak;
    logic        dec_jump;
    logic        dec_rd_w_en;
    logic        dec_mem_en;
    logic        dec_mem_wr;
    logic [63:0] jump_target;
    logic        mem_req_valid;
    logic        mem_req_we;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic        rf_we;
    logic        halt;
    logic        trap;
    logic [2:0]  trap_code;
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_22040237_mcyc_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_addr       (if_addr),
        .if_resp_valid (if_resp_valid),
        .if_resp_inst  (if_resp_inst),
        .ir            (ir),
        .pc            (pc),
        .dec_invalid   (dec_invalid),
        .dec_ebreak    (dec_ebreak),
        .dec_jump      (dec_jump),
        .dec_rd_w_en   (dec_rd_w_en),
        .dec_mem_en    (dec_mem_en),
        .dec_mem_wr    (dec_mem_wr),
        .jump_target   (jump_target),
        .mem_req_valid (mem_req_valid),
        .mem_req_we    (mem_req_we),
        .mem_req_ready (mem_req_ready),
        .mem_resp_valid(mem_resp_valid),
        .rf_we         (rf_we),
        .halt          (halt),
        .trap          (trap),
        .trap_code     (trap_code),
        .cycle_cnt     (cycle_cnt),
        .instret_cnt   (instret_cnt)
    );

    always #5 clk = ~clk;

    // advance one clock and settle 1 time unit past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [63:0] frozen;
        rst = 1'b1;
        if_req_ready = 1'b0; if_resp_valid = 1'b0; if_resp_inst = 32'd0;
        dec_invalid = 1'b0; dec_ebreak = 1'b0; dec_jump = 1'b0;
        dec_rd_w_en = 1'b0; dec_mem_en = 1'b0; dec_mem_wr = 1'b0;
        jump_target = 64'd0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;

        // ---- reset state ----
        ticks(2);
        chk("rst_pc",      pc, RPC);
        chk("rst_ir",      64'(ir), 64'd0);
        chk("rst_rf_we",   64'(rf_we), 64'd0);
        chk("rst_memreq",  64'(mem_req_valid), 64'd0);
        chk("rst_halt",    64'(halt), 64'd0);
        chk("rst_trap",    64'(trap), 64'd0);
        chk("rst_code",    64'(trap_code), 64'd0);
        chk("rst_cycle",   cycle_cnt, 64'd0);
        chk("rst_instret", instret_cnt, 64'd0);
        rst = 1'b0;

        // ---- addi stream, ready/resp always 1 ----
        if_req_ready = 1'b1; if_resp_valid = 1'b1; if_resp_inst = 32'h0010_0093;
        dec_rd_w_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("addi_ifvalid", 64'(if_req_valid), 64'd1);
            chk("addi_ifaddr",  if_addr, RPC + 64'(4 * i));
            tick();
            chk("addi_ifvalid_drop", 64'(if_req_valid), 64'd0);
            tick();
            chk("addi_ir",      64'(ir), 64'h0010_0093);
            chk("addi_nowe",    64'(rf_we), 64'd0);
            ticks(2);
            chk("addi_we",      64'(rf_we), 64'd1);
            tick();
            chk("addi_we_drop", 64'(rf_we), 64'd0);
        end
        chk("addi_instret", instret_cnt, 64'd3);
        chk("addi_cycle",   cycle_cnt, 64'd15);
        chk("addi_pc",      pc, 64'h8000_000C);

        // ---- jal to 0x80000101 -> pc 0x80000100 ----
        if_resp_inst = 32'h1000_00EF;
        dec_jump = 1'b1; jump_target = 64'h8000_0101;
        ticks(4);
        chk("jal_we", 64'(rf_we), 64'd1);
        tick();
        chk("jal_pc", pc, 64'h8000_0100);
        chk("jal_ifaddr", if_addr, 64'h8000_0100);

        // ---- jump to 0x80000102 -> misaligned trap ----
        jump_target = 64'h8000_0102;
        ticks(4);
        chk("mis_nowe", 64'(rf_we), 64'd0);
        chk("mis_notrap_yet", 64'(trap), 64'd0);
        tick();
        chk("mis_trap", 64'(trap), 64'd1);
        chk("mis_code", 64'(trap_code), 64'd4);
        chk("mis_pc",   pc, 64'h8000_0100);
        chk("mis_cycle", cycle_cnt, 64'd25);
        chk("mis_instret", instret_cnt, 64'd4);
        ticks(2);
        chk("mis_cycle_frozen", cycle_cnt, 64'd25);
        chk("mis_no_ifreq", 64'(if_req_valid), 64'd0);
        chk("mis_nowe_after", 64'(rf_we), 64'd0);

        // ---- load with response delayed 3 cycles ----
        rst = 1'b1; tick(); rst = 1'b0;
        chk("ld_rst_trap", 64'(trap), 64'd0);
        chk("ld_rst_pc", pc, RPC);
        dec_jump = 1'b0; dec_mem_en = 1'b1; dec_mem_wr = 1'b0; dec_rd_w_en = 1'b1;
        if_resp_inst = 32'h0000_3083;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
        ticks(4);
        chk("ld_memreq", 64'(mem_req_valid), 64'd1);
        chk("ld_we_flag", 64'(mem_req_we), 64'd0);
        tick();
        chk("ld_memreq_drop", 64'(mem_req_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ld_wait_nowe", 64'(rf_we), 64'd0);
        end
        mem_resp_valid = 1'b1;
        tick();
        chk("ld_we", 64'(rf_we), 64'd1);
        mem_resp_valid = 1'b0;
        tick();
        chk("ld_pc", pc, RPC + 64'd4);
        chk("ld_instret", instret_cnt, 64'd1);
        chk("ld_cycle", cycle_cnt, 64'd10);

        // ---- store: one stall cycle, then WB right after ready ----
        dec_mem_wr = 1'b1; dec_rd_w_en = 1'b0; mem_req_ready = 1'b0;
        if_resp_inst = 32'h0010_3023;
        ticks(4);
        chk("st_memreq", 64'(mem_req_valid), 64'd1);
        chk("st_we_flag", 64'(mem_req_we), 64'd1);
        tick();
        chk("st_hold", 64'(mem_req_valid), 64'd1);
        mem_req_ready = 1'b1;
        tick();
        chk("st_memreq_drop", 64'(mem_req_valid), 64'd0);
        chk("st_pc_in_wb", pc, RPC + 64'd4);
        chk("st_nowe", 64'(rf_we), 64'd0);
        tick();
        chk("st_pc", pc, RPC + 64'd8);
        chk("st_instret", instret_cnt, 64'd2);
        chk("st_cycle", cycle_cnt, 64'd17);

        // ---- fetch timeout after 255 cycles without response ----
        dec_mem_en = 1'b0; dec_mem_wr = 1'b0; mem_req_ready = 1'b0;
        if_resp_valid = 1'b0;
        tick();
        ticks(254);
        chk("tmo_not_yet", 64'(trap), 64'd0);
        tick();
        chk("tmo_trap", 64'(trap), 64'd1);
        chk("tmo_code", 64'(trap_code), 64'd2);
        chk("tmo_cycle", cycle_cnt, 64'd273);
        if_resp_valid = 1'b1;
        ticks(2);
        chk("tmo_cycle_frozen", cycle_cnt, 64'd273);
        chk("tmo_no_ifreq", 64'(if_req_valid), 64'd0);
        chk("tmo_no_memreq", 64'(mem_req_valid), 64'd0);
        chk("tmo_ir_kept", 64'(ir), 64'h0010_3023);

        // ---- ebreak halts ----
        rst = 1'b1; tick(); rst = 1'b0;
        dec_ebreak = 1'b1; dec_rd_w_en = 1'b0; if_resp_inst = 32'h0010_0073;
        ticks(2);
        chk("ebk_ir", 64'(ir), 64'h0010_0073);
        tick();
        chk("ebk_halt", 64'(halt), 64'd1);
        chk("ebk_notrap", 64'(trap), 64'd0);
        chk("ebk_nowe", 64'(rf_we), 64'd0);
        chk("ebk_cycle", cycle_cnt, 64'd3);
        ticks(2);
        chk("ebk_cycle_frozen", cycle_cnt, 64'd3);
        chk("ebk_no_ifreq", 64'(if_req_valid), 64'd0);
        chk("ebk_instret", instret_cnt, 64'd0);

        // ---- invalid wins over ebreak ----
        rst = 1'b1; tick(); rst = 1'b0;
        chk("inv_rst_halt", 64'(halt), 64'd0);
        dec_invalid = 1'b1;
        ticks(3);
        chk("inv_trap", 64'(trap), 64'd1);
        chk("inv_code", 64'(trap_code), 64'd1);
        chk("inv_halt", 64'(halt), 64'd0);

        // ---- reset in the middle of a data request ----
        rst = 1'b1; tick(); rst = 1'b0;
        dec_invalid = 1'b0; dec_ebreak = 1'b0; dec_rd_w_en = 1'b1;
        if_resp_inst = 32'h0010_0093;
        ticks(5);
        chk("mid_pc_adv", pc, RPC + 64'd4);
        dec_mem_en = 1'b1; mem_req_ready = 1'b0;
        ticks(5);
        chk("mid_memreq", 64'(mem_req_valid), 64'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_memreq_drop", 64'(mem_req_valid), 64'd0);
        chk("mid_pc", pc, RPC);
        chk("mid_cycle", cycle_cnt, 64'd0);
        chk("mid_instret", instret_cnt, 64'd0);
        chk("mid_ifreq", 64'(if_req_valid), 64'd1);

        // ---- pc wraps past the top of the address space ----
        dec_mem_en = 1'b0; dec_jump = 1'b1; jump_target = 64'hFFFF_FFFF_FFFF_FFFD;
        ticks(5);
        chk("wrap_jump_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        dec_jump = 1'b0;
        ticks(5);
        chk("wrap_pc", pc, 64'd0);
        chk("wrap_instret", instret_cnt, 64'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22040237_mcyc_ctrl.md
Name: ysyx_22040237_mcyc_ctrl

Overview:
Multi-cycle sequencer for the RV64 core datapath.
- Owns the PC and instruction register, drives the fetch and data-memory valid/ready handshakes, and steps the combinational decoder/ALU through FETCH→DECODE→EXEC→MEM→WB.
- Gates register-file writes and PC updates to one strobe per instruction.
- Detects ebreak halt and fault traps for simulation.

Parameters:
RESET_PC, 64'h8000_0000, PC value loaded on reset
TIMEOUT, 255, max cycles waiting for any memory response before trapping (8-bit watchdog)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
if_req_valid  out  1  instruction fetch request
if_req_ready  in  1  fetch request accepted
if_addr  out  64  fetch address (= pc)
if_resp_valid  in  1  fetch data valid
if_resp_inst  in  32  fetched instruction
ir  out  32  instruction register, feeds decoder
pc  out  64  current PC, feeds decoder
dec_invalid  in  1  decoder invalid_inst
dec_ebreak  in  1  decoder inst_ebreak
dec_jump  in  1  decoder jump_flag
dec_rd_w_en  in  1  decoder rd write enable
dec_mem_en  in  1  instruction accesses data memory
dec_mem_wr  in  1  access is a store
jump_target  in  64  ALU jump-target sum
mem_req_valid  out  1  data memory request
mem_req_we  out  1  store when 1
mem_req_ready  in  1  data request accepted
mem_resp_valid  in  1  load data valid
rf_we  out  1  register-file write strobe
halt  out  1  ebreak reached (sticky)
trap  out  1  fault (sticky)
trap_code  out  3  1 invalid inst, 2 fetch timeout, 3 load timeout, 4 misaligned jump
cycle_cnt  out  64  cycles while running
instret_cnt  out  64  retired instructions

Behaviour:
- Reset: state=FETCH; pc=RESET_PC; ir=0; all strobes, halt, trap, trap_code, counters and watchdog =0. rst mid-handshake aborts it; no retire.
- FETCH: if_req_valid=1, if_addr=pc. if_req_valid holds until if_req_ready, which moves to WAIT_I.
- WAIT_I: on if_resp_valid, ir←if_resp_inst → DECODE. Otherwise the watchdog increments; at TIMEOUT → TRAP, code 2.
- DECODE (1 cycle, uses new ir):
  - dec_invalid → TRAP, code 1.
  - else dec_ebreak → HALT.
  - else → EXEC.
  - dec_invalid has priority over dec_ebreak.
- EXEC (1 cycle): dec_mem_en → MEM, else → WB.
- MEM: mem_req_valid=1 and mem_req_we=dec_mem_wr, held until mem_req_ready. On ready: store → WB; load → WAIT_D.
- WAIT_D: on mem_resp_valid → WB. Watchdog at TIMEOUT → TRAP, code 3.
- Watchdog clears on every state entry.
- WB (1 cycle):
  - target = {jump_target[63:1],1'b0}.
  - If dec_jump and target[1]=1 → TRAP, code 4. No rf_we, pc unchanged.
  - Otherwise rf_we=dec_rd_w_en for exactly this cycle; pc←dec_jump ? target : pc+4; instret_cnt+1 → FETCH.
- Latency: a non-memory instruction with 1-cycle fetch handshake and response takes 5 cycles. A load adds ≥2 cycles; a store adds ≥1.
- HALT/TRAP are terminal until rst. halt or trap=1; no requests and no strobes; counters frozen.
- cycle_cnt increments every non-terminal cycle; both counters wrap at 2^64.
- Responses arriving outside WAIT_I/WAIT_D are ignored. Ready inputs are ignored when valid=0.
- pc+4 wraps modulo 2^64.

Test Plan:
- Reset, then addi stream with ready/resp always 1 → if_addr 0x80000000, 0x80000004, …; one rf_we pulse per 5 cycles; instret_cnt=N after 5N cycles.
- jal with jump_target 0x80000101 → pc=0x80000100 and rf_we pulsed; target 0x80000102 → trap=1, code 4, no rf_we, pc unchanged.
- Load with mem_resp_valid delayed 3 cycles → rf_we only after the response; store → no WAIT_D, WB one cycle after mem_req_ready.
- if_resp_valid withheld 255 cycles → trap code 2; requests stop; cycle_cnt frozen.
- Instruction 0x00100073 → halt=1 with no rf_we; instruction with dec_invalid=1 and dec_ebreak=1 → trap code 1, halt=0.
- rst asserted while mem_req_valid=1 → next cycle state FETCH, pc=RESET_PC, counters 0, mem_req_valid=0.
